motor_pos_ctrl: RTL and testbench

MOTOR_POS_CTRL -- requirements
Module: motor_pos_ctrl

---
 rtl/motor_pos_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_motor_pos_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pos_ctrl.sv
// Closed-loop position controller: drives a PWM-gated motor toward a captured target, then settles.
// Latency: target accepted on the transfer edge, MOVE from the next cycle; outputs registered (1-cycle lag on decisions).
// Backpressure: tgt_ready is high only in IDLE without abort; requests outside IDLE are ignored, not queued.
//
// Ports:
//   clk, resetn       - rising-edge clock, asynchronous active-low reset
//   count[31:0]       - encoder position (two's complement), synchronous to clk
//   tgt[31:0]         - requested target; tgt_valid/tgt_ready handshake
//   abort             - cancels a move or settle, returns to IDLE next cycle
//   duty[PWM_BITS-1:0]- drive strength, sampled live each cycle
//   pwm, dir          - motor enable (PWM-modulated) and direction (1 = toward larger count)
//   busy, done, stall - not-IDLE flag, completion pulse, stall-abort pulse
//
// Optional build macro STALL_DETECT_EN: enables stall detection (count frozen for
// STALL_CYCLES consecutive cycles in MOVE). Without it the stall output is held 0.

module motor_pos_ctrl #(
    parameter int DEADBAND      = 4,
    parameter int PWM_BITS      = 8,
    parameter int SETTLE_CYCLES = 1000,
    parameter int STALL_CYCLES  = 1000000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [31:0]         count,
    input  logic [31:0]         tgt,
    input  logic                tgt_valid,
    output logic                tgt_ready,
    input  logic                abort,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic                stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Settle counter only needs to reach SETTLE_CYCLES-1; the completing cycle is
    // detected by comparison rather than by counting one past it.
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t                state;
    logic [31:0]           target;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [SETTLE_W-1:0]   settle_cnt;

    logic [31:0]           err;
    logic [31:0]           abs_err;
    logic                  in_band;
    logic                  stall_hit;

    // Subtraction modulo 2^32 keeps the error correct across the count wrap point.
    assign err = target - count;

    // Magnitude of the signed error; -2^31 has no positive counterpart, so clamp it.
    always_comb begin
        abs_err = err;
        if (err[31]) begin
            if (err == 32'h8000_0000) begin
                abs_err = 32'h7FFF_FFFF;
            end else begin
                abs_err = ~err + 32'd1;
            end
        end
    end

    assign in_band   = (abs_err <= 32'(DEADBAND));
    assign tgt_ready = (state == IDLE) && !abort;

`ifdef STALL_DETECT_EN
    localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

    logic [STALL_W-1:0] stall_cnt;
    logic [31:0]        last_count;
    logic               count_same;

    assign count_same = (count == last_count);
    // stall_cnt counts earlier unchanged cycles; this cycle being unchanged too
    // makes STALL_CYCLES in a row.
    assign stall_hit  = count_same && (stall_cnt == STALL_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt  <= '0;
            last_count <= '0;
        end else begin
            last_count <= count;
            // Only an uninterrupted out-of-band MOVE cycle with a frozen count
            // advances the counter; anything else restarts it.
            if (state == MOVE && !abort && !in_band && count_same) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end else begin
                stall_cnt <= '0;
            end
        end
    end
`else
    assign stall_hit = 1'b0;
    logic unused_stall_cycles;
    assign unused_stall_cycles = (STALL_CYCLES < 1);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            target     <= '0;
            pwm_cnt    <= '0;
            settle_cnt <= '0;
            pwm        <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stall      <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            // Pulses and drive default low; only an active MOVE cycle re-enables pwm.
            pwm     <= 1'b0;
            done    <= 1'b0;
            stall   <= 1'b0;

            case (state)
                IDLE: begin
                    if (tgt_valid && !abort) begin
                        target     <= tgt;
                        state      <= MOVE;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                    end
                end

                MOVE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (in_band) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end else if (stall_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        stall <= 1'b1;
                    end else begin
                        // Out of band means err is non-zero, so the sign bit alone
                        // decides direction.
                        dir <= ~err[31];
                        pwm <= (pwm_cnt < duty);
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!in_band) begin
                        state      <= MOVE;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_pos_ctrl.sv
module tb_motor_pos_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] count;
    logic [31:0] tgt;
    logic        tgt_valid;
    logic        tgt_ready;
    logic        abort;
    logic [7:0]  duty;
    logic        pwm;
    logic        dir;
    logic        busy;
    logic        done;
    logic        stall;

    int tests = 0;
    int fails = 0;
    int hi;
    int done_cnt;
    int done_at;
    int stall_seen;
    int stall_at;

    motor_pos_ctrl #(
        .DEADBAND      (4),
        .PWM_BITS      (8),
        .SETTLE_CYCLES (1000),
        .STALL_CYCLES  (50)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .count     (count),
        .tgt       (tgt),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .abort     (abort),
        .duty      (duty),
        .pwm       (pwm),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps n cycles and records how many done pulses appear and at which step.
    task automatic watch_done(input int n);
        done_cnt = 0;
        done_at  = -1;
        for (int k = 1; k <= n; k++) begin
            step();
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
    endtask

    task automatic count_pwm(input int n);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (pwm === 1'b1) hi++;
        end
    endtask

    initial begin
        resetn    = 1'b0;
        count     = 32'd0;
        tgt       = 32'd0;
        tgt_valid = 1'b0;
        abort     = 1'b0;
        duty      = 8'd0;
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_pwm", {31'd0, pwm}, 32'd0);
        check("reset_dir", {31'd0, dir}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        // First transfer right on the first edge after reset release.
        resetn    = 1'b1;
        tgt       = 32'd100;
        tgt_valid = 1'b1;
        duty      = 8'd128;
        #1;
        check("idle_tgt_ready", {31'd0, tgt_ready}, 32'd1);
        step();
        tgt_valid = 1'b0;
        check("move_busy", {31'd0, busy}, 32'd1);
        step();
        check("move_dir_up", {31'd0, dir}, 32'd1);

        count_pwm(256);
        check("pwm_duty128", hi, 32'd128);
        duty = 8'd0;
        count_pwm(256);
        check("pwm_duty0", hi, 32'd0);
        duty = 8'd255;
        count_pwm(256);
        check("pwm_duty255", hi, 32'd255);
        duty = 8'd128;

        // Coarse ramp that skips the deadband edge, then land at 97 (error 3).
        for (int c = 0; c <= 88; c += 8) begin
            count = c;
            step();
        end
        check("ramp_busy", {31'd0, busy}, 32'd1);
        count = 32'd97;
        step();
        check("settle_pwm", {31'd0, pwm}, 32'd0);
        watch_done(1010);
        check("done_count", done_cnt, 32'd1);
        check("done_latency", done_at, 32'd1000);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_ready", {31'd0, tgt_ready}, 32'd1);

        // Settle disturbed by an overshoot: return to MOVE driving downward.
        count     = 32'd98;
        tgt       = 32'd100;
        tgt_valid = 1'b1;
        step();
        tgt_valid = 1'b0;
        step();
        check("settle2_pwm", {31'd0, pwm}, 32'd0);
        for (int k = 0; k < 10; k++) step();
        count = 32'd110;
        step();
        step();
        check("overshoot_dir", {31'd0, dir}, 32'd0);
        check("overshoot_busy", {31'd0, busy}, 32'd1);
        count = 32'd100;
        step();
        watch_done(1010);
        check("restart_done_count", done_cnt, 32'd1);
        check("restart_done_latency", done_at, 32'd1000);

        // Target just across the signed wrap: error is +32.
        count     = 32'h7FFF_FFF0;
        tgt       = 32'h8000_0010;
        tgt_valid = 1'b1;
        step();
        tgt_valid = 1'b0;
        step();
        check("wrap_dir", {31'd0, dir}, 32'd1);
        check("wrap_busy", {31'd0, busy}, 32'd1);

        // Abort together with a new request mid-MOVE.
        duty = 8'd255;
        step();
        step();
        abort     = 1'b1;
        tgt_valid = 1'b1;
        tgt       = 32'd5;
        #1;
        check("abort_ready", {31'd0, tgt_ready}, 32'd0);
        step();
        abort     = 1'b0;
        tgt_valid = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_pwm", {31'd0, pwm}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        watch_done(5);
        check("abort_no_accept", {31'd0, busy}, 32'd0);
        check("abort_no_done", done_cnt, 32'd0);

        // Frozen encoder during MOVE.
        count     = 32'd0;
        tgt       = 32'd1000;
        tgt_valid = 1'b1;
        step();
        tgt_valid = 1'b0;
        stall_seen = 0;
        stall_at   = -1;
        done_cnt   = 0;
`ifdef STALL_DETECT_EN
        for (int k = 1; k <= 60; k++) begin
            step();
            if (stall === 1'b1) begin
                stall_seen++;
                if (stall_at < 0) stall_at = k;
            end
            if (done === 1'b1) done_cnt++;
        end
        check("stall_count", stall_seen, 32'd1);
        check("stall_latency", stall_at, 32'd50);
        check("stall_busy", {31'd0, busy}, 32'd0);
        check("stall_no_done", done_cnt, 32'd0);
`else
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (stall === 1'b1) stall_seen++;
            if (done === 1'b1) done_cnt++;
        end
        check("nostall_busy", {31'd0, busy}, 32'd1);
        check("nostall_pulse", stall_seen, 32'd0);
        check("nostall_done", done_cnt, 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("nostall_abort", {31'd0, busy}, 32'd0);
`endif

        // Asynchronous reset in the middle of a move.
        count     = 32'd0;
        tgt       = 32'd500;
        tgt_valid = 1'b1;
        step();
        tgt_valid = 1'b0;
        step();
        step();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        check("pre_reset_dir", {31'd0, dir}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_pwm", {31'd0, pwm}, 32'd0);
        check("async_reset_dir", {31'd0, dir}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
